// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_pkg;

    typedef enum logic {
        IDLE,
        WAIT
    } mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte/half/word lane steering for stores and loads, plus alignment check.
module lsu_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_value,
    output logic        misaligned
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Select the addressed byte and half of the returned load word.
    always_comb begin
        lane_byte = load_word[7:0];
        case (addr_lo)
            2'd0:    lane_byte = load_word[7:0];
            2'd1:    lane_byte = load_word[15:8];
            2'd2:    lane_byte = load_word[23:16];
            default: lane_byte = load_word[31:24];
        endcase
        lane_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    end

    // Replicate store data across lanes, build strobes, extend load data.
    always_comb begin
        wdata      = '0;
        wstrb      = '0;
        load_value = '0;
        misaligned = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                wdata      = {4{store_data[7:0]}};
                wstrb      = 4'b0001 << addr_lo;
                load_value = (funct3 == F3_B) ? {{24{lane_byte[7]}}, lane_byte}
                                              : {24'b0, lane_byte};
            end
            F3_H, F3_HU: begin
                wdata      = {2{store_data[15:0]}};
                wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
                load_value = (funct3 == F3_H) ? {{16{lane_half[15]}}, lane_half}
                                              : {16'b0, lane_half};
                misaligned = addr_lo[0];
            end
            F3_W: begin
                wdata      = store_data;
                wstrb      = '1;
                load_value = load_word;
                misaligned = (addr_lo != 2'b00);
            end
            default: begin
                wdata      = '0;
                wstrb      = '0;
                load_value = '0;
                misaligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM and MEM/WB registers, data-memory handshake FSM
// and the stall raised while an access is outstanding.
module mem_stage
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_mem_write_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_reg_write,
    output logic [4:0]  mem_rd,
    output logic [31:0] mem_forward_value,
    output logic        misaligned,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    mem_state_t  state;

    logic        m_valid;
    logic        m_read;
    logic        m_write;
    logic [2:0]  m_funct3;
    logic        m_reg_write;
    logic [4:0]  m_rd;
    logic [31:0] m_alu;
    logic [31:0] m_wdata;

    logic [31:0] al_wdata;
    logic [3:0]  al_wstrb;
    logic [31:0] al_load;
    logic        al_mis;

    logic        mem_op;
    logic        mis_acc;
    logic        op_live;
    logic        store_done;
    logic        load_accept;
    logic        load_done;

    lsu_align u_align (
        .addr_lo    (m_alu[1:0]),
        .funct3     (m_funct3),
        .store_data (m_wdata),
        .load_word  (dmem_rdata),
        .wdata      (al_wdata),
        .wstrb      (al_wstrb),
        .load_value (al_load),
        .misaligned (al_mis)
    );

    // Request, completion and stall decode from the held EX/MEM op.
    always_comb begin
        mem_op      = m_valid & (m_read | m_write);
        mis_acc     = mem_op & al_mis;
        op_live     = mem_op & ~al_mis;
        dmem_req    = op_live & (state == IDLE);
        dmem_we     = dmem_req & m_write;
        dmem_addr   = dmem_req ? {m_alu[31:2], 2'b00} : '0;
        dmem_wdata  = dmem_we ? al_wdata : '0;
        dmem_wstrb  = dmem_we ? al_wstrb : '0;
        store_done  = dmem_req & dmem_ready & m_write;
        load_accept = dmem_req & dmem_ready & ~m_write;
        load_done   = (state == WAIT) & dmem_rvalid;
        mem_stall   = op_live & ~(store_done | load_done);
        misaligned  = mis_acc;
        mem_reg_write     = m_valid & m_reg_write & ~m_read;
        mem_rd            = m_rd;
        mem_forward_value = m_alu;
    end

    // EX/MEM register: captures the EX op unless the stage is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid     <= 1'b0;
            m_read      <= 1'b0;
            m_write     <= 1'b0;
            m_funct3    <= '0;
            m_reg_write <= 1'b0;
            m_rd        <= '0;
            m_alu       <= '0;
            m_wdata     <= '0;
        end else if (!mem_stall) begin
            m_valid     <= ex_valid;
            m_read      <= ex_mem_read;
            m_write     <= ex_mem_write;
            m_funct3    <= ex_funct3;
            m_reg_write <= ex_reg_write;
            m_rd        <= ex_rd;
            m_alu       <= ex_alu_result;
            m_wdata     <= ex_mem_write_data;
        end
    end

    // Handshake FSM: a load waits here for rvalid once accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (load_accept) state <= WAIT;
                WAIT:    if (dmem_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // MEM/WB register: bubble while stalled; misaligned ops retire without a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
        end else if (mem_stall) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
        end else begin
            wb_valid     <= m_valid;
            wb_reg_write <= m_valid & m_reg_write & ~mis_acc;
            wb_rd        <= m_rd;
            wb_data      <= (m_read & ~mis_acc) ? al_load : m_alu;
        end
    end

endmodule
